stc_dbuffer_pp: RTL and testbench

STC_DBUFFER_PP -- requirements
Module: stc_dbuffer_pp

---
 rtl/stc_dbuffer_pp.sv | 210 +++++++++++++++++++++
 tb/tb_stc_dbuffer_pp.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stc_dbuffer_pp.sv
// Double-buffered row store for a systolic tensor core.
// One bank serves the PEs (combinational row reads, overwrite/accumulate
// writes); the other bank is filled by row loads and streamed out through a
// valid/ready drain port. The two banks exchange roles on swap, deferred
// until any drain in progress has completed.
module stc_dbuffer_pp #(
    parameter int N       = 16,
    parameter int M       = 16,
    parameter int N_PE    = 4,
    parameter int DW_DATA = 16,
    parameter int DW_COL  = 4,
    parameter int DW_MEM  = N*DW_DATA
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_en,
    input  logic [DW_COL-1:0]           load_col,
    input  logic [DW_MEM-1:0]           C_input,
    input  logic [N_PE-1:0]             pe_wr_en,
    input  logic [N_PE-1:0]             pe_acc,
    input  logic [N_PE*DW_COL-1:0]      cols_in,
    input  logic [N_PE*N*DW_DATA-1:0]   D_rows,
    input  logic [N_PE*DW_COL-1:0]      cols_out,
    output logic [N_PE*N*DW_DATA-1:0]   C_rows,
    input  logic                        swap,
    input  logic                        drain_start,
    output logic                        drain_valid,
    input  logic                        drain_ready,
    output logic [DW_COL-1:0]           drain_col,
    output logic [N*DW_DATA-1:0]        D_row_out,
    output logic                        busy,
    output logic                        err_collision
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [DW_COL-1:0] LAST_ROW = DW_COL'(M - 1);

    // Row indices can exceed the bank depth when M < 2**DW_COL.
    function automatic logic row_ok(input logic [DW_COL-1:0] r);
        return int'(r) < M;
    endfunction

    // Storage: bank[b][row][element].
    logic [DW_DATA-1:0] bank [2][M][N];

    state_t             state, state_d;
    logic [DW_COL-1:0]  counter, counter_d;
    logic               bank_sel, bank_sel_d;
    logic               swap_pending, swap_pending_d;
    logic               err_d;
    logic               io_sel;

    logic [DW_COL-1:0]  wr_col [N_PE];
    logic [DW_COL-1:0]  rd_col [N_PE];
    logic [N_PE-1:0]    wr_lost;
    logic [N_PE-1:0]    wr_win;
    logic               load_ok;

    assign io_sel = ~bank_sel;

    for (genvar g = 0; g < N_PE; g++) begin : g_pe_idx
        assign wr_col[g] = cols_in[g*DW_COL +: DW_COL];
        assign rd_col[g] = cols_out[g*DW_COL +: DW_COL];
    end

    // Arbitrate PE writes: on equal row index the lowest-index PE wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        wr_lost = '0;
        wr_win  = '0;
        for (int i = 0; i < N_PE; i++) begin
            for (int j = 0; j < i; j++) begin
                if (pe_wr_en[i] && pe_wr_en[j] && (wr_col[i] == wr_col[j])) begin
                    wr_lost[i] = 1'b1;
                end
            end
            wr_win[i] = pe_wr_en[i] && !wr_lost[i] && row_ok(wr_col[i]);
        end
        err_d = |wr_lost;
    end

    assign load_ok = load_en && (state == IDLE) && row_ok(load_col);

    // PE read ports: combinational, so a same-cycle write is not yet visible.
    always_comb begin
        C_rows = '0;
        for (int i = 0; i < N_PE; i++) begin
            for (int e = 0; e < N; e++) begin
                if (row_ok(rd_col[i])) begin
                    C_rows[(i*N + e)*DW_DATA +: DW_DATA] = bank[bank_sel][rd_col[i]][e];
                end
            end
        end
    end

    // Drain port outputs: the IO-bank row addressed by the counter.
    always_comb begin
        drain_valid = (state == DRAIN);
        drain_col   = '0;
        D_row_out   = '0;
        if (state == DRAIN) begin
            drain_col = counter;
            for (int e = 0; e < N; e++) begin
                D_row_out[e*DW_DATA +: DW_DATA] = bank[io_sel][counter][e];
            end
        end
    end

    assign busy = (state == DRAIN) | swap_pending;

    // Drain FSM and bank-swap scheduling.
    always_comb begin
        state_d        = state;
        counter_d      = counter;
        bank_sel_d     = bank_sel;
        swap_pending_d = swap_pending;

        case (state)
            IDLE: begin
                if (drain_start) begin
                    state_d   = DRAIN;
                    counter_d = '0;
                end
            end
            DRAIN: begin
                if (drain_ready) begin
                    if (counter == LAST_ROW) begin
                        state_d   = IDLE;
                        counter_d = '0;
                    end else begin
                        counter_d = counter + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A deferred swap fires in the first IDLE cycle after the drain.
        if ((state == IDLE) && swap_pending) begin
            bank_sel_d     = ~bank_sel;
            swap_pending_d = 1'b0;
        end

        // Swaps arriving while one is already pending merge into it.
        if (swap && !swap_pending) begin
            if ((state == IDLE) && !drain_start) begin
                bank_sel_d = ~bank_sel;
            end else begin
                swap_pending_d = 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state is assigned with <= so every register samples the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state         <= IDLE;
            counter       <= '0;
            bank_sel      <= 1'b0;
            swap_pending  <= 1'b0;
            err_collision <= 1'b0;
        end else begin
            state         <= state_d;
            counter       <= counter_d;
            bank_sel      <= bank_sel_d;
            swap_pending  <= swap_pending_d;
            err_collision <= err_d;
        end
    end

    // Bank storage: row loads into the IO bank, PE writes into the compute bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the banks must read as zero straight out of reset, so the
            // storage is built from resettable flops rather than a RAM macro.
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < M; r++) begin
                    for (int e = 0; e < N; e++) begin
                        bank[b][r][e] <= '0;
                    end
                end
            end
        end else begin
            if (load_ok) begin
                for (int e = 0; e < N; e++) begin
                    bank[io_sel][load_col][e] <= C_input[e*DW_DATA +: DW_DATA];
                end
            end
            for (int i = 0; i < N_PE; i++) begin
                if (wr_win[i]) begin
                    for (int e = 0; e < N; e++) begin
                        bank[bank_sel][wr_col[i]][e] <= pe_acc[i]
                            ? bank[bank_sel][wr_col[i]][e] + D_rows[(i*N + e)*DW_DATA +: DW_DATA]
                            : D_rows[(i*N + e)*DW_DATA +: DW_DATA];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stc_dbuffer_pp.sv
// Self-checking bench for stc_dbuffer_pp (default parameters).
// Keeps a behavioural model of the two banks as "compute" and "IO" arrays
// that are exchanged on swap, plus a drain row index and pending-swap flag.
module tb_stc_dbuffer_pp;

    localparam int N    = 16;
    localparam int M    = 16;
    localparam int NPE  = 4;
    localparam int DW   = 16;
    localparam int DWC  = 4;
    localparam int ROWW = N*DW;

    typedef logic [DW-1:0] bank_t [M][N];

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  load_en = 1'b0;
    logic [DWC-1:0]        load_col = '0;
    logic [ROWW-1:0]       C_input = '0;
    logic [NPE-1:0]        pe_wr_en = '0;
    logic [NPE-1:0]        pe_acc = '0;
    logic [NPE*DWC-1:0]    cols_in = '0;
    logic [NPE*ROWW-1:0]   D_rows = '0;
    logic [NPE*DWC-1:0]    cols_out = '0;
    logic [NPE*ROWW-1:0]   C_rows;
    logic                  swap = 1'b0;
    logic                  drain_start = 1'b0;
    logic                  drain_valid;
    logic                  drain_ready = 1'b0;
    logic [DWC-1:0]        drain_col;
    logic [ROWW-1:0]       D_row_out;
    logic                  busy;
    logic                  err_collision;

    int n_assert = 0;
    int n_fail   = 0;

    bank_t m_cmp, m_io;
    bit    m_draining, m_pending, exp_err;
    int    m_idx;

    stc_dbuffer_pp dut (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_col(load_col), .C_input(C_input),
        .pe_wr_en(pe_wr_en), .pe_acc(pe_acc), .cols_in(cols_in), .D_rows(D_rows),
        .cols_out(cols_out), .C_rows(C_rows),
        .swap(swap), .drain_start(drain_start),
        .drain_valid(drain_valid), .drain_ready(drain_ready),
        .drain_col(drain_col), .D_row_out(D_row_out),
        .busy(busy), .err_collision(err_collision)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [ROWW-1:0] cmp_row(input int r);
        logic [ROWW-1:0] v;
        for (int e = 0; e < N; e++) v[e*DW +: DW] = m_cmp[r][e];
        return v;
    endfunction

    function automatic logic [ROWW-1:0] io_row(input int r);
        logic [ROWW-1:0] v;
        for (int e = 0; e < N; e++) v[e*DW +: DW] = m_io[r][e];
        return v;
    endfunction

    function automatic logic [ROWW-1:0] rand_row();
        logic [ROWW-1:0] v;
        for (int w = 0; w < ROWW/32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < M; r++)
            for (int e = 0; e < N; e++) begin
                m_cmp[r][e] = '0;
                m_io[r][e]  = '0;
            end
        m_draining = 0;
        m_pending  = 0;
        m_idx      = 0;
        exp_err    = 0;
    endtask

    // Advance one clock: update the model from the inputs now applied, then
    // move to 1 time unit after the rising edge.
    task automatic cycle();
        bank_t old, tmp;
        bit    was_draining, pend_before, do_toggle, coll;
        int    c;
        logic [DW-1:0] d;
        old          = m_cmp;
        was_draining = m_draining;
        pend_before  = m_pending;
        do_toggle    = 0;
        coll         = 0;
        // Highest index first so the lowest enabled PE lands last and wins.
        for (int i = NPE-1; i >= 0; i--) begin
            if (pe_wr_en[i]) begin
                c = int'(cols_in[i*DWC +: DWC]);
                for (int e = 0; e < N; e++) begin
                    d = D_rows[(i*N + e)*DW +: DW];
                    m_cmp[c][e] = pe_acc[i] ? DW'(old[c][e] + d) : d;
                end
                for (int j = 0; j < i; j++)
                    if (pe_wr_en[j] && cols_in[j*DWC +: DWC] == cols_in[i*DWC +: DWC]) coll = 1;
            end
        end
        if (load_en && !was_draining)
            for (int e = 0; e < N; e++) m_io[load_col][e] = C_input[e*DW +: DW];
        if (!was_draining && pend_before) begin
            do_toggle = 1;
            m_pending = 0;
        end
        if (swap && !pend_before) begin
            if (!was_draining && !drain_start) do_toggle = 1;
            else m_pending = 1;
        end
        if (!was_draining && drain_start) begin
            m_draining = 1;
            m_idx      = 0;
        end else if (was_draining && drain_ready) begin
            m_idx++;
            if (m_idx == M) begin
                m_draining = 0;
                m_idx      = 0;
            end
        end
        if (do_toggle) begin
            tmp   = m_cmp;
            m_cmp = m_io;
            m_io  = tmp;
        end
        exp_err = coll;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 256'(drain_valid), 256'(m_draining));
        check({tag, ".busy"}, 256'(busy), 256'(m_draining | m_pending));
        check({tag, ".err"}, 256'(err_collision), 256'(exp_err));
        if (m_draining) begin
            check({tag, ".col"}, 256'(drain_col), 256'(m_idx));
            check({tag, ".data"}, D_row_out, io_row(m_idx));
        end
        for (int i = 0; i < NPE; i++)
            check({tag, ".c_rows"}, C_rows[i*ROWW +: ROWW], cmp_row(int'(cols_out[i*DWC +: DWC])));
    endtask

    task automatic rand_pe();
        pe_wr_en = 4'($urandom);
        pe_acc   = 4'($urandom);
        cols_in  = 16'($urandom);
        cols_out = 16'($urandom);
        for (int i = 0; i < NPE; i++) D_rows[i*ROWW +: ROWW] = rand_row();
    endtask

    task automatic quiet();
        pe_wr_en    = '0;
        pe_acc      = '0;
        load_en     = 1'b0;
        swap        = 1'b0;
        drain_start = 1'b0;
        drain_ready = 1'b0;
    endtask

    initial begin
        model_reset();

        // Outputs while reset is held.
        repeat (2) @(posedge clk);
        #1;
        cols_out = 16'($urandom);
        #1;
        check_outputs("reset");
        check("reset.col", 256'(drain_col), '0);
        check("reset.data", D_row_out, '0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Load IO rows with their own index, swap, read rows 3,2,1,0.
        for (int r = 0; r < M; r++) begin
            load_en  = 1'b1;
            load_col = 4'(r);
            C_input  = {N{16'(r)}};
            #1;
            check_outputs("load");
            cycle();
        end
        load_en = 1'b0;
        swap    = 1'b1;
        #1;
        check_outputs("swap");
        cycle();
        swap     = 1'b0;
        cols_out = {4'd3, 4'd2, 4'd1, 4'd0};
        #1;
        check_outputs("rows3210");
        for (int i = 0; i < NPE; i++)
            check("rows3210.value", C_rows[i*ROWW +: ROWW], {N{16'(i)}});

        // Overwrite row 5 with 7, accumulate 3; wrap 1 + 0xFFFF on row 6.
        pe_wr_en = 4'b0001;
        pe_acc   = 4'b0000;
        cols_in  = 16'h0005;
        cols_out = 16'h0005;
        D_rows   = '0;
        D_rows[0 +: ROWW] = {N{16'd7}};
        #1;
        check_outputs("ovw5");
        cycle();
        pe_acc = 4'b0001;
        D_rows[0 +: ROWW] = {N{16'd3}};
        #1;
        check("acc5.read_old", C_rows[0 +: ROWW], {N{16'd7}});
        check_outputs("acc5");
        cycle();
        pe_wr_en = 4'b0000;
        #1;
        check("acc5.sum", C_rows[0 +: ROWW], {N{16'd10}});
        pe_wr_en = 4'b0001;
        pe_acc   = 4'b0000;
        cols_in  = 16'h0006;
        D_rows[0 +: ROWW] = {N{16'd1}};
        #1;
        check_outputs("ovw6");
        cycle();
        pe_acc = 4'b0001;
        D_rows[0 +: ROWW] = {N{16'hFFFF}};
        #1;
        check_outputs("acc6");
        cycle();
        pe_wr_en = 4'b0000;
        cols_out = 16'h0006;
        #1;
        check("acc6.wrap", C_rows[0 +: ROWW], '0);

        // PE0 and PE2 collide on row 4.
        pe_wr_en = 4'b0101;
        pe_acc   = 4'b0000;
        cols_in  = {4'd0, 4'd4, 4'd0, 4'd4};
        D_rows   = '0;
        D_rows[0 +: ROWW]      = {N{16'd1}};
        D_rows[2*ROWW +: ROWW] = {N{16'd9}};
        cols_out = 16'h0004;
        #1;
        check_outputs("coll");
        cycle();
        pe_wr_en = 4'b0000;
        #1;
        check("coll.err", 256'(err_collision), 256'(1));
        check("coll.row4", C_rows[0 +: ROWW], {N{16'd1}});
        cycle();
        #1;
        check("coll.err_clear", 256'(err_collision), '0);

        // Random PE traffic with loads and immediate swaps in IDLE.
        for (int k = 0; k < 60; k++) begin
            rand_pe();
            load_en  = ($urandom_range(0, 3) == 0);
            load_col = 4'($urandom);
            C_input  = rand_row();
            swap     = ($urandom_range(0, 7) == 0);
            #1;
            check_outputs("rand");
            cycle();
        end
        quiet();

        // Drain with drain_ready toggling every cycle; a stray drain_start mid-drain.
        drain_start = 1'b1;
        #1;
        check_outputs("drain.start");
        cycle();
        drain_start = 1'b0;
        for (int k = 0; k < 80 && m_draining; k++) begin
            drain_ready = ((k % 2) == 1);
            drain_start = (k == 5);
            #1;
            check_outputs("drain");
            cycle();
        end
        quiet();
        #1;
        check_outputs("drain.end");

        // Swap requested at row 6 and a load attempted during the drain.
        drain_start = 1'b1;
        #1;
        check_outputs("swapdrain.start");
        cycle();
        drain_start = 1'b0;
        drain_ready = 1'b1;
        for (int k = 0; k < 40 && (m_draining || m_pending); k++) begin
            rand_pe();
            swap     = m_draining && (m_idx == 6);
            load_en  = m_draining && (m_idx == 6);
            load_col = 4'd2;
            C_input  = rand_row();
            #1;
            check_outputs("swapdrain");
            cycle();
        end
        quiet();
        cols_out = {4'd2, 4'd6, 4'd2, 4'd15};
        #1;
        check_outputs("swapdrain.after");

        // Reset asserted while row 8 is being presented.
        drain_start = 1'b1;
        #1;
        check_outputs("rstdrain.start");
        cycle();
        drain_start = 1'b0;
        drain_ready = 1'b1;
        for (int k = 0; k < 40 && m_draining && m_idx < 8; k++) begin
            rand_pe();
            #1;
            check_outputs("rstdrain");
            cycle();
        end
        check("rstdrain.reached_row8", 256'(m_idx), 256'(8));
        quiet();
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs("rstdrain.in_reset");
        check("rstdrain.col", 256'(drain_col), '0);
        check("rstdrain.data", D_row_out, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int q = 0; q < M/NPE; q++) begin
            cols_out = {4'(4*q + 3), 4'(4*q + 2), 4'(4*q + 1), 4'(4*q)};
            #1;
            check_outputs("post_reset.read");
            cycle();
        end
        drain_start = 1'b1;
        #1;
        check_outputs("post_reset.drain_start");
        cycle();
        drain_start = 1'b0;
        drain_ready = 1'b1;
        for (int k = 0; k < 40 && m_draining; k++) begin
            #1;
            check_outputs("post_reset.drain");
            cycle();
        end
        quiet();
        #1;
        check_outputs("post_reset.end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
